filter_ctrl: RTL and testbench

Sequencing and configuration controller for the ROM-fed IIR filter pair. Owns the sample ROM address counter, paces samples at a programmable rate, and issues a filter-reset flush before every run. Aligns a filter clock-enable with ROM read latency. Holds both filters' coefficient sets in a shadow/active register bank that updates atomically between samples. Sits between the sample ROM and the low-pass/high-pass filter instances, replacing the free-running address counter and the hard-wired coefficients.

---
 rtl/filter_pkg.sv | 20 ++
 rtl/coef_bank.sv | 63 ++++++
 rtl/filter_ctrl.sv | 150 +++++++++++++++
 tb/tb_filter_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the filter sequencing controller and its coefficient bank.
package filter_pkg;

  typedef logic [15:0] coef_t;

  localparam int unsigned NUM_COEF = 3;

  typedef enum logic {
    LP = 1'b0,
    HP = 1'b1
  } channel_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/coef_bank.sv
// Shadow/active coefficient registers for both filters; the active set is replaced
// atomically at an edge where the controller says no sample is mid-flight.
module coef_bank
  import filter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_sel,
  input  logic [1:0]  cfg_idx,
  input  logic [15:0] cfg_data,
  input  logic        cfg_commit,
  input  logic        copy_ok,
  output logic [47:0] lp_coef,
  output logic [47:0] hp_coef,
  output logic        cfg_pending
);

  coef_t shadow_q [2][NUM_COEF];
  coef_t shadow_d [2][NUM_COEF];
  coef_t active_q [2][NUM_COEF];
  logic  pending_q;
  logic  copy;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we && (cfg_idx < 2'(NUM_COEF))) begin
      shadow_d[cfg_sel][cfg_idx] = cfg_data;
    end
    copy = pending_q && copy_ok;
  end

  // Copy from shadow_d so a write landing on the copy edge is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          shadow_q[c][i] <= '0;
          active_q[c][i] <= '0;
        end
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (copy) begin
        active_q <= shadow_d;
      end
      pending_q <= cfg_commit | (pending_q & ~copy);
    end
  end

  always_comb begin
    lp_coef = '0;
    hp_coef = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      lp_coef[16*i +: 16] = active_q[LP][i];
      hp_coef[16*i +: 16] = active_q[HP][i];
    end
  end

  assign cfg_pending = pending_q;

endmodule

// File: rtl/filter_ctrl.sv
// Run sequencer for the ROM-fed IIR pair: flush, paced ROM addressing, ce aligned to
// ROM latency, and drain so in-flight samples still reach the filters.
module filter_ctrl
  import filter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned ROM_LAT    = 2,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [1:0]        cfg_idx,
  input  logic [15:0]       cfg_data,
  input  logic              cfg_commit,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              filter_rst,
  output logic              filter_ce,
  output logic [47:0]       lp_coef,
  output logic [47:0]       hp_coef,
  output logic              busy,
  output logic              done,
  output logic              cfg_pending
);

  ctrl_state_t       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;  // shared FLUSH/DRAIN length counter
  logic [DIV_W-1:0]  div_q, div_cnt_q, div_cnt_d;
  logic              single_q;
  logic [ADDR_W-1:0] last_q, addr_q, addr_d;
  logic [ROM_LAT-1:0] ce_pipe_q;
  logic              filter_rst_q, done_q, done_d;
  logic              tick, latch, at_last, copy_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_cnt_d = div_cnt_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    tick      = 1'b0;
    latch     = 1'b0;
    at_last   = (addr_q == last_q);
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FLUSH;
          cnt_d   = '0;
          addr_d  = '0;
          latch   = 1'b1;
        end
      end
      FLUSH: begin
        // Preload so the first RUN cycle ticks.
        div_cnt_d = div_q;
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == 8'(RST_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (div_cnt_q == div_q) begin
          tick      = 1'b1;
          div_cnt_d = '0;
          addr_d    = at_last ? '0 : addr_q + 1'b1;
          if (at_last && single_q) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == 8'(ROM_LAT - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      div_cnt_q    <= '0;
      single_q     <= 1'b0;
      last_q       <= '0;
      addr_q       <= '0;
      ce_pipe_q    <= '0;
      filter_rst_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      addr_q    <= addr_d;
      if (latch) begin
        div_q    <= div;
        single_q <= single;
        last_q   <= last_addr;
      end
      ce_pipe_q    <= (ce_pipe_q << 1) | ROM_LAT'(tick);
      filter_rst_q <= (state_d == FLUSH);
      done_q       <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign filter_rst = filter_rst_q;
  assign filter_ce  = ce_pipe_q[ROM_LAT-1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // Safe to swap coefficients when no run is active or a sample is being consumed.
  assign copy_ok = (state_q == IDLE) || (state_q == FLUSH) || filter_ce;

  coef_bank u_coef_bank (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .copy_ok     (copy_ok),
    .lp_coef     (lp_coef),
    .hp_coef     (hp_coef),
    .cfg_pending (cfg_pending)
  );

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl: cycle-by-cycle sequences against hand-derived tables.
module tb_filter_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, single;
  logic [15:0] div;
  logic [14:0] last_addr;
  logic        cfg_we, cfg_sel, cfg_commit;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_data;
  logic [14:0] rom_addr;
  logic        filter_rst, filter_ce, busy, done, cfg_pending;
  logic [47:0] lp_coef, hp_coef;

  int checks = 0;
  int errors = 0;

  filter_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .single      (single),
    .div         (div),
    .last_addr   (last_addr),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .rom_addr    (rom_addr),
    .filter_rst  (filter_rst),
    .filter_ce   (filter_ce),
    .lp_coef     (lp_coef),
    .hp_coef     (hp_coef),
    .busy        (busy),
    .done        (done),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({rom_addr, filter_rst, filter_ce, busy, done, cfg_pending, lp_coef, hp_coef} !==
        {15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 48'd0}) begin
      errors++;
      $display("FAIL reset_values got addr=%0d frst=%b ce=%b busy=%b done=%b pend=%b lp=%h hp=%h exp 0 1 0 0 0 0 0 0",
               rom_addr, filter_rst, filter_ce, busy, done, cfg_pending, lp_coef, hp_coef);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({filter_rst, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got frst=%b busy=%b exp 0 0", filter_rst, busy);
    end
  endtask

  task automatic test_single_pass();
    logic [18:0] got, exp;
    div = 16'd0; single = 1'b1; last_addr = 15'd3;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      exp = {15'((c >= 5 && c <= 8) ? c - 5 : 0), 1'(c >= 1 && c <= 4), 1'(c >= 7 && c <= 10),
             1'(c >= 1 && c <= 10), 1'(c == 11)};
      got = {rom_addr, filter_rst, filter_ce, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_pass c=%0d got addr=%0d frst=%b ce=%b busy=%b done=%b exp addr=%0d frst=%b ce=%b busy=%b done=%b",
                 c, got[18:4], got[3], got[2], got[1], got[0], exp[18:4], exp[3], exp[2], exp[1], exp[0]);
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, filter_rst} !== 2'b00) begin
      errors++;
      $display("FAIL start_stop_idle got busy=%b frst=%b exp 0 0", busy, filter_rst);
    end
    step();
    checks++;
    if ({busy, filter_rst, done} !== 3'b000) begin
      errors++;
      $display("FAIL start_stop_idle2 got busy=%b frst=%b done=%b exp 0 0 0", busy, filter_rst, done);
    end
  endtask

  // div=2 wrap run with a start pulse mid-run, an LP c1 commit between ticks, then stop.
  task automatic test_continuous();
    logic [18:0] got, exp;
    logic [16:0] gotc, expc;
    div = 16'd2; single = 1'b0; last_addr = 15'd1;
    cfg_sel = 1'b0; cfg_idx = 2'd1; cfg_data = 16'h00FC;
    for (int c = 0; c <= 20; c++) begin
      start      = (c == 0) || (c == 9);
      stop       = (c == 15);
      cfg_we     = (c == 9);
      cfg_commit = (c == 11);
      exp = {15'((c <= 5 || c >= 15) ? 0 : ((c - 6) / 3 + 1) % 2), 1'(c >= 1 && c <= 4),
             1'(c == 7 || c == 10 || c == 13 || c == 16), 1'(c >= 1 && c <= 17), 1'(c == 18)};
      got = {rom_addr, filter_rst, filter_ce, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL continuous c=%0d got addr=%0d frst=%b ce=%b busy=%b done=%b exp addr=%0d frst=%b ce=%b busy=%b done=%b",
                 c, got[18:4], got[3], got[2], got[1], got[0], exp[18:4], exp[3], exp[2], exp[1], exp[0]);
      end
      expc = {1'(c == 12 || c == 13), (c >= 14) ? 16'h00FC : 16'h0000};
      gotc = {cfg_pending, lp_coef[31:16]};
      checks++;
      if (gotc !== expc) begin
        errors++;
        $display("FAIL midrun_commit c=%0d got pend=%b lp_c1=%h exp pend=%b lp_c1=%h",
                 c, gotc[16], gotc[15:0], expc[16], expc[15:0]);
      end
      step();
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic test_hp_commit_idle();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 2'd3; cfg_data = 16'hFFFF;
    step();
    cfg_sel = 1'b1; cfg_idx = 2'd2; cfg_data = 16'h80FC; cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    checks++;
    if ({cfg_pending, hp_coef} !== {1'b1, 48'd0}) begin
      errors++;
      $display("FAIL hp_commit_pending got pend=%b hp=%h exp pend=1 hp=0", cfg_pending, hp_coef);
    end
    step();
    checks++;
    if ({cfg_pending, hp_coef, lp_coef} !== {1'b0, 48'h80FC_0000_0000, 48'h0000_00FC_0000}) begin
      errors++;
      $display("FAIL hp_commit_copy got pend=%b hp=%h lp=%h exp pend=0 hp=80fc00000000 lp=000000fc0000",
               cfg_pending, hp_coef, lp_coef);
    end
  endtask

  task automatic test_flush_stop();
    logic [2:0] got, exp;
    div = 16'd0; single = 1'b1; last_addr = 15'd3;
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      stop  = (c == 2);
      exp = {1'(c == 1 || c == 2), 1'(c == 1 || c == 2), 1'b0};
      got = {busy, filter_rst, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL flush_stop c=%0d got busy=%b frst=%b done=%b exp busy=%b frst=%b done=%b",
                 c, got[2], got[1], got[0], exp[2], exp[1], exp[0]);
      end
      step();
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_rst_midrun();
    div = 16'd0; single = 1'b0; last_addr = 15'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    checks++;
    if ({rom_addr, busy} !== {15'd2, 1'b1}) begin
      errors++;
      $display("FAIL rst_midrun_pre got addr=%0d busy=%b exp addr=2 busy=1", rom_addr, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rom_addr, filter_rst, filter_ce, busy, done, cfg_pending, lp_coef, hp_coef} !==
        {15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0, 48'd0}) begin
      errors++;
      $display("FAIL rst_midrun got addr=%0d frst=%b ce=%b busy=%b done=%b pend=%b lp=%h hp=%h exp 0 1 0 0 0 0 0 0",
               rom_addr, filter_rst, filter_ce, busy, done, cfg_pending, lp_coef, hp_coef);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({done, busy, filter_ce} !== 3'b000) begin
        errors++;
        $display("FAIL rst_midrun_after k=%0d got done=%b busy=%b ce=%b exp 0 0 0",
                 c, done, busy, filter_ce);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0; div = '0; last_addr = '0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_commit = 1'b0;
    test_reset();
    test_single_pass();
    test_start_stop_idle();
    test_continuous();
    test_hp_commit_idle();
    test_flush_stop();
    test_rst_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
